// File: rtl/hilo_unit_pkg.sv
// Shared function codes and HI/LO sequencing states for the HI/LO unit and its divider core.
package hilo_unit_pkg;

    localparam logic [5:0] FUN_MFHI  = 6'h10;
    localparam logic [5:0] FUN_MTHI  = 6'h11;
    localparam logic [5:0] FUN_MFLO  = 6'h12;
    localparam logic [5:0] FUN_MTLO  = 6'h13;
    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        HILO_IDLE = 2'd0,
        HILO_ITER = 2'd1,
        HILO_FIX  = 2'd2
    } hilo_state_t;

    function automatic logic is_div_op(input logic [5:0] f);
        return (f == FUN_DIV) || (f == FUN_DIVU);
    endfunction

endpackage

// File: rtl/hilo_unit_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle; result is valid while in HILO_FIX.
// Optional HILO_EARLY_OUT_EN skips the iterations for a zero divisor or dividend < divisor.
module hilo_unit_div_core
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    hilo_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] dvs_reg;

    // quo_reg shifts the dividend out of its top while quotient bits enter at the bottom
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= HILO_IDLE;
            cnt_reg   <= '0;
            rem_reg   <= '0;
            quo_reg   <= '0;
            dvs_reg   <= '0;
        end else if (flush) begin
            state_reg <= HILO_IDLE;
        end else begin
            case (state_reg)
                HILO_IDLE: begin
                    if (start) begin
                        dvs_reg   <= divisor;
                        quo_reg   <= dividend;
                        rem_reg   <= '0;
                        cnt_reg   <= CNT_W'(WIDTH);
                        state_reg <= HILO_ITER;
`ifdef HILO_EARLY_OUT_EN
                        if (divisor == '0) begin
                            quo_reg   <= '1;
                            rem_reg   <= dividend;
                            cnt_reg   <= '0;
                            state_reg <= HILO_FIX;
                        end else if (dividend < divisor) begin
                            quo_reg   <= '0;
                            rem_reg   <= dividend;
                            cnt_reg   <= '0;
                            state_reg <= HILO_FIX;
                        end
`endif
                    end
                end
                HILO_ITER: begin
                    if (diff[WIDTH]) begin
                        rem_reg <= shifted[WIDTH-1:0];
                    end else begin
                        rem_reg <= diff[WIDTH-1:0];
                    end
                    quo_reg <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= HILO_FIX;
                    end
                end
                HILO_FIX: begin
                    state_reg <= HILO_IDLE;
                end
                default: begin
                    state_reg <= HILO_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != HILO_IDLE);
    assign done      = (state_reg == HILO_FIX);
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner: commits MULT/MULTU products, MTHI/MTLO, and signed/unsigned divides.
// Build with HILO_EARLY_OUT_EN to let trivial divides skip the iterative phase.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] aluLo,
    input  logic [WIDTH-1:0] aluHi,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             done_reg;
    logic             q_neg_reg;
    logic             r_neg_reg;
    logic             dbz_reg;

    logic             accept;
    logic             is_signed;
    logic             core_busy;
    logic             core_done;
    logic             commit;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    assign accept    = start && !flush && !core_busy;
    assign is_signed = (funct == FUN_DIV);

    // Magnitudes wrap modulo 2^WIDTH, so the most negative dividend maps onto itself
    assign dividend_mag = (is_signed && opA[WIDTH-1]) ? -opA : opA;
    assign divisor_mag  = (is_signed && opB[WIDTH-1]) ? -opB : opB;

    hilo_unit_div_core #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_div_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_div_op(funct)),
        .flush    (flush),
        .dividend (dividend_mag),
        .divisor  (divisor_mag),
        .busy     (core_busy),
        .done     (core_done),
        .quotient (core_quo),
        .remainder(core_rem)
    );

    // A zero divisor always reports an all-ones quotient, whatever the operand signs
    assign quo_final = (q_neg_reg && !dbz_reg) ? -core_quo : core_quo;
    assign rem_final = r_neg_reg ? -core_rem : core_rem;
    assign commit    = core_done && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg    <= '0;
            lo_reg    <= '0;
            done_reg  <= 1'b0;
            q_neg_reg <= 1'b0;
            r_neg_reg <= 1'b0;
            dbz_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (commit) begin
                lo_reg   <= quo_final;
                hi_reg   <= rem_final;
                done_reg <= 1'b1;
            end else if (accept) begin
                case (funct)
                    FUN_MULT, FUN_MULTU: begin
                        hi_reg <= aluHi;
                        lo_reg <= aluLo;
                    end
                    FUN_MTHI: hi_reg <= opA;
                    FUN_MTLO: lo_reg <= opA;
                    FUN_DIV, FUN_DIVU: begin
                        q_neg_reg <= is_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                        r_neg_reg <= is_signed && opA[WIDTH-1];
                        dbz_reg   <= (opB == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = core_busy;
    assign done = done_reg;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed-vector bench for hilo_unit: single-cycle ops, divides, flush and asynchronous reset.
module tb_hilo_unit;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_BOGUS = 6'h2A;

`ifdef HILO_EARLY_OUT_EN
    localparam int LAT_TRIVIAL = 1;
`else
    localparam int LAT_TRIVIAL = 33;
`endif
    localparam int LAT_FULL = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [31:0] aluLo;
    logic [31:0] aluHi;
    logic        flush;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .funct(funct),
        .opA  (opA),
        .opB  (opB),
        .aluLo(aluLo),
        .aluHi(aluHi),
        .flush(flush),
        .hi   (hi),
        .lo   (lo),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        funct = f; opA = a; opB = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Starts a divide and measures how many sampled cycles busy stays high and how many done pulses occur
    task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           output int cycles, output int dones);
        issue(f, a, b);
        cycles = 0;
        dones = 0;
        while (busy && cycles < 200) begin
            if (done) dones++;
            cycles++;
            tick();
        end
        if (done) dones++;
        tick();
        if (done) dones++;
    endtask

    task automatic test_reset();
        checks++; if (hi !== 32'h0)  begin failures++; $display("FAIL reset_hi got %h exp %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0)  begin failures++; $display("FAIL reset_lo got %h exp %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
        $display("reset: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
    endtask

    task automatic test_mult();
        aluHi = 32'hFFFF_FFFF; aluLo = 32'hFFFF_FFFA;
        issue(F_MULT, 32'h0, 32'h0);
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got %h exp %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin failures++; $display("FAIL mult_lo got %h exp %h", lo, 32'hFFFF_FFFA); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mult_busy got %b exp 0", busy); end
        $display("mult: hi=%h lo=%h busy=%b", hi, lo, busy);
        aluHi = 32'h0; aluLo = 32'h0;
        issue(F_MTHI, 32'h0000_1111, 32'h0);
        issue(F_MTLO, 32'h0000_2222, 32'h0);
        issue(F_BOGUS, 32'h0000_9999, 32'h0);
        checks++; if (hi !== 32'h0000_1111) begin failures++; $display("FAIL mthi got %h exp %h", hi, 32'h0000_1111); end
        checks++; if (lo !== 32'h0000_2222) begin failures++; $display("FAIL mtlo_bogus got %h exp %h", lo, 32'h0000_2222); end
        $display("mthi/mtlo/bogus: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_divu();
        int cyc, dn;
        run_div(F_DIVU, 32'd100, 32'd7, cyc, dn);
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL divu_lo got %0d exp 14", lo); end
        checks++; if (hi !== 32'd2)  begin failures++; $display("FAIL divu_hi got %0d exp 2", hi); end
        checks++; if (cyc != LAT_FULL) begin failures++; $display("FAIL divu_busy_cycles got %0d exp %0d", cyc, LAT_FULL); end
        checks++; if (dn != 1) begin failures++; $display("FAIL divu_done_pulses got %0d exp 1", dn); end
        $display("divu 100/7: lo=%0d hi=%0d busy_cycles=%0d dones=%0d", lo, hi, cyc, dn);
    endtask

    task automatic test_div_signed();
        int cyc, dn;
        run_div(F_DIV, 32'hFFFF_FFF9, 32'd2, cyc, dn);
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo got %h exp %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi got %h exp %h", hi, 32'hFFFF_FFFF); end
        $display("div -7/2: lo=%h hi=%h busy_cycles=%0d", lo, hi, cyc);
        run_div(F_DIV, 32'd7, 32'hFFFF_FFFE, cyc, dn);
        checks++; if (lo !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_negb_lo got %h exp %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL div_negb_hi got %h exp %h", hi, 32'd1); end
        $display("div 7/-2: lo=%h hi=%h", lo, hi);
        run_div(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn);
        checks++; if (lo !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got %h exp %h", lo, 32'h8000_0000); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got %h exp %h", hi, 32'h0); end
        checks++; if (dn != 1) begin failures++; $display("FAIL div_ovf_done got %0d exp 1", dn); end
        $display("div 0x80000000/-1: lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_div_zero();
        int cyc, dn;
        run_div(F_DIVU, 32'h0000_1234, 32'h0, cyc, dn);
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dbz_lo got %h exp %h", lo, 32'hFFFF_FFFF); end
        checks++; if (hi !== 32'h0000_1234) begin failures++; $display("FAIL dbz_hi got %h exp %h", hi, 32'h0000_1234); end
        checks++; if (cyc != LAT_TRIVIAL) begin failures++; $display("FAIL dbz_busy_cycles got %0d exp %0d", cyc, LAT_TRIVIAL); end
        $display("divu 0x1234/0: lo=%h hi=%h busy_cycles=%0d", lo, hi, cyc);
        run_div(F_DIV, 32'hFFFF_FFFB, 32'h0, cyc, dn);
        checks++; if (lo !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dbz_s_lo got %h exp %h", lo, 32'hFFFF_FFFF); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin failures++; $display("FAIL dbz_s_hi got %h exp %h", hi, 32'hFFFF_FFFB); end
        $display("div -5/0: lo=%h hi=%h", lo, hi);
        run_div(F_DIVU, 32'd5, 32'd9, cyc, dn);
        checks++; if (lo !== 32'd0 || hi !== 32'd5) begin failures++; $display("FAIL small_div got lo=%h hi=%h exp lo=0 hi=5", lo, hi); end
        checks++; if (cyc != LAT_TRIVIAL) begin failures++; $display("FAIL small_div_cycles got %0d exp %0d", cyc, LAT_TRIVIAL); end
        $display("divu 5/9: lo=%h hi=%h busy_cycles=%0d", lo, hi, cyc);
    endtask

    task automatic test_flush();
        int dn;
        issue(F_MTHI, 32'h0000_AAAA, 32'h0);
        issue(F_MTLO, 32'h0000_5555, 32'h0);
        issue(F_DIV, 32'd1000, 32'd3);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy_start got %b exp 1", busy); end
        for (int i = 0; i < 5; i++) tick();
        issue(F_MTLO, 32'd5, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (lo !== 32'h0000_5555) begin failures++; $display("FAIL mtlo_while_busy got %h exp %h", lo, 32'h0000_5555); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got %b exp 0", busy); end
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dn++;
            tick();
        end
        checks++; if (dn != 0) begin failures++; $display("FAIL flush_done got %0d exp 0", dn); end
        checks++; if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
            failures++; $display("FAIL flush_hilo got hi=%h lo=%h exp hi=0000aaaa lo=00005555", hi, lo);
        end
        $display("flush: hi=%h lo=%h busy=%b dones=%0d", hi, lo, busy, dn);
        flush = 1'b1;
        issue(F_DIVU, 32'd50, 32'd5);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_with_start got %b exp 0", busy); end
        $display("flush+start: busy=%b", busy);
    endtask

    task automatic test_async_reset();
        int cyc, dn;
        issue(F_MTHI, 32'h0000_BEEF, 32'h0);
        issue(F_DIVU, 32'd1000, 32'd7);
        for (int i = 0; i < 14; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin failures++; $display("FAIL areset_hilo got hi=%h lo=%h exp 0", hi, lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got %b exp 0", busy); end
        $display("async reset: hi=%h lo=%h busy=%b", hi, lo, busy);
        #1 rst_n = 1'b1;
        tick();
        run_div(F_DIVU, 32'd9, 32'd3, cyc, dn);
        checks++; if (lo !== 32'd3 || hi !== 32'd0) begin failures++; $display("FAIL post_reset_div got lo=%h hi=%h exp lo=3 hi=0", lo, hi); end
        $display("post-reset divu 9/3: lo=%0d hi=%0d", lo, hi);
    endtask

    task automatic test_back_to_back();
        int cyc;
        issue(F_DIVU, 32'd77, 32'd10);
        cyc = 0;
        while (!done && cyc < 200) begin
            cyc++;
            tick();
        end
        aluHi = 32'h0000_0001; aluLo = 32'h0000_0002;
        issue(F_MULT, 32'h0, 32'h0);
        aluHi = 32'h0; aluLo = 32'h0;
        checks++; if (hi !== 32'h1 || lo !== 32'h2) begin failures++; $display("FAIL b2b_mult got hi=%h lo=%h exp hi=1 lo=2", hi, lo); end
        $display("back-to-back mult after divide: hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; funct = 6'h0; opA = '0; opB = '0;
        aluLo = '0; aluHi = '0; flush = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_mult();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
